fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one FIFO write port among NUM_REQ requesters, e.g. several command sources feeding the single UART TX FIFO.
- Grants are packet-locked: the winning requester keeps the port until its last beat, or until MAX_BURST beats, so that packets from different sources do not interleave.
- Sits between the requesters and the FIFO's data/write-enable/full interface. Uses valid/ready on the requester side.

---
 rtl/fifo_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port among NUM_REQ valid/ready
// requesters. Round-robin arbitration, grants held for a whole packet
// (or until MAX_BURST beats) so packets from different sources never interleave.

// Structural checker: the grant vector is never more than one-hot.
module fifo_wr_arbiter_chk #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] grant_i
);
    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(grant_i));
endmodule

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic                          fifo_wr_en_o,
    input  logic                          fifo_full_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;

    logic [PTR_W-1:0]     g_idx_s;
    logic                 gnt_valid_s;
    logic                 gnt_last_s;
    logic                 wr_en_s;

    // First requester with valid set, scanning from ptr upward and wrapping.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] win;
        logic [PTR_W-1:0] cand;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end else begin
                win   = win;
            end
        end
        return win;
    endfunction

    // Binary index of a one-hot (or zero) vector.
    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign g_idx_s      = oh_to_idx(grant_q);
    assign gnt_valid_s  = |(req_valid_i & grant_q);
    assign gnt_last_s   = |(req_last_i & grant_q);
    assign wr_en_s      = (state_q == ST_BUSY) & gnt_valid_s & ~fifo_full_i;

    assign fifo_wr_en_o = wr_en_s;
    assign req_ready_o  = (state_q == ST_BUSY) ? (grant_q & {NUM_REQ{~fifo_full_i}})
                                               : {NUM_REQ{1'b0}};
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == ST_BUSY);

    // Write-data mux: AND-OR select of the granted requester's beat.
    always_comb begin
        fifo_data_o = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_data_o = fifo_data_o
                        | (req_data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
        end
    end

    // Next state: arbitrate in IDLE; count beats and release in BUSY.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    state_d    = ST_BUSY;
                    grant_d    = ONE_HOT_0 << rr_pick(req_valid_i, rr_ptr_q);
                    beat_cnt_d = {CNT_W{1'b0}};
                end else begin
                    grant_d    = {NUM_REQ{1'b0}};
                end
            end
            ST_BUSY: begin
                if (wr_en_s) begin
                    if (gnt_last_s || (beat_cnt_q == CNT_LAST)) begin
                        // Served requester drops to lowest priority.
                        state_d    = ST_IDLE;
                        grant_d    = {NUM_REQ{1'b0}};
                        beat_cnt_d = {CNT_W{1'b0}};
                        rr_ptr_d   = (g_idx_s == PTR_LAST) ? {PTR_W{1'b0}}
                                                           : (g_idx_s + PTR_W'(1));
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Stalled on full FIFO or requester gap: hold everything.
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = {NUM_REQ{1'b0}};
                rr_ptr_d   = {PTR_W{1'b0}};
                beat_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers: FSM state, one-hot grant, round-robin pointer, beat counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= {NUM_REQ{1'b0}};
            rr_ptr_q   <= {PTR_W{1'b0}};
            beat_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    fifo_wr_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .grant_i (grant_q)
    );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a cycle-level behavioural model
// and per-test literal expectations on the observed write/grant streams.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last  = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic            fifo_full = 1'b0;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   fifo_data_o;
    logic            fifo_wr_en_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_last_i   (req_last),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_full_i  (fifo_full),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] src_q [N][$];   // {last, data} per requester
    logic [7:0] wr_data_q[$];
    int         wr_src_q[$];
    int         wr_cyc_q[$];
    int         gnt_src_q[$];
    int         gnt_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Requester sources: present queue heads, pop on an accepted beat.
    initial begin : sources
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready_o;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    req_valid[k]           = 1'b1;
                    req_last[k]            = src_q[k][0][8];
                    req_data[k*DW +: DW]   = src_q[k][0][7:0];
                end else begin
                    req_valid[k]           = 1'b0;
                    req_last[k]            = 1'b0;
                    req_data[k*DW +: DW]   = '0;
                end
            end
        end
    end

    // Behavioural model and per-cycle comparison, plus logging of DUT activity.
    initial begin : compare
        int owner;
        int prio;
        int beats;
        logic [N-1:0]  e_grant, e_ready, prev_grant;
        logic          e_wr, e_busy;
        logic [DW-1:0] e_data;
        owner = -1; prio = 0; beats = 0; prev_grant = '0;
        forever begin
            @(negedge clk);
            cyc++;
            e_grant = '0; e_ready = '0; e_wr = 1'b0; e_busy = 1'b0; e_data = '0;
            if (!rst && owner >= 0) begin
                e_grant = N'(1) << owner;
                e_busy  = 1'b1;
                e_data  = req_data[owner*DW +: DW];
                if (!fifo_full) begin
                    e_ready = e_grant;
                    e_wr    = |(req_valid & e_grant);
                end
            end
            chk("grant", 32'(grant_o), 32'(e_grant));
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("ready", 32'(req_ready_o), 32'(e_ready));
            chk("wr_en", 32'(fifo_wr_en_o), 32'(e_wr));
            if (e_wr) chk("data", 32'(fifo_data_o), 32'(e_data));

            if (fifo_wr_en_o === 1'b1) begin
                wr_data_q.push_back(fifo_data_o);
                wr_src_q.push_back(oh_idx(grant_o));
                wr_cyc_q.push_back(cyc);
            end
            if (grant_o != '0 && prev_grant == '0) begin
                gnt_src_q.push_back(oh_idx(grant_o));
                gnt_cyc_q.push_back(cyc);
            end
            prev_grant = grant_o;

            if (rst) begin
                owner = -1; prio = 0; beats = 0;
            end else if (owner < 0) begin
                if (|req_valid) begin
                    for (int i = 0; i < N; i++) begin
                        int c;
                        c = (prio + i) % N;
                        if (owner < 0 && req_valid[c]) owner = c;
                    end
                    beats = 0;
                end
            end else if (e_wr) begin
                beats++;
                if (|(req_last & e_grant) || beats == MB) begin
                    prio  = (owner + 1) % N;
                    owner = -1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        src_q[k].push_back({l, d});
    endtask

    task automatic clear_logs();
        wr_data_q.delete(); wr_src_q.delete(); wr_cyc_q.delete();
        gnt_src_q.delete(); gnt_cyc_q.delete();
    endtask

    task automatic wait_wr(input int n, input int budget);
        int c;
        c = 0;
        while (wr_data_q.size() < n && c < budget) begin
            @(negedge clk);
            #1;
            c++;
        end
        chk("wait_writes", 32'(wr_data_q.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        fifo_full = 1'b0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        clear_logs();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] exp_d[$];
        int         exp_s[$];
        int         c;

        // Reset state
        @(negedge clk); #1;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        clear_logs();

        // Requester 2: 3-beat packet
        step();
        push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
        c = 0;
        while (req_valid[2] !== 1'b1 && c < 10) begin @(negedge clk); #1; c++; end
        chk("t2_valid_seen", 32'(req_valid[2]), 32'd1);
        @(negedge clk); #1;
        chk("t2_grant_latency", 32'(grant_o), 32'b0100);
        wait_wr(3, 20);
        chk("t2_d0", 32'(wr_data_q[0]), 32'hA1);
        chk("t2_d1", 32'(wr_data_q[1]), 32'hA2);
        chk("t2_d2", 32'(wr_data_q[2]), 32'hA3);
        chk("t2_src", 32'(wr_src_q[2]), 32'd2);
        chk("t2_consecutive", 32'(wr_cyc_q[2] - wr_cyc_q[0]), 32'd2);
        @(negedge clk); #1;
        chk("t2_release", 32'(grant_o), 32'd0);

        // All four requesters, two 1-beat packets each
        do_reset();
        step();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < N; k++) push(k, 8'(8'h10 * k + p), 1'b1);
        wait_wr(8, 60);
        chk("t3_grants", 32'(gnt_src_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t3_order", 32'(gnt_src_q[i]), 32'(i % 4));
            chk("t3_one_busy", 32'(wr_cyc_q[i]), 32'(gnt_cyc_q[i]));
            if (i > 0) chk("t3_idle_gap", 32'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 32'd2);
        end

        // MAX_BURST forced release: requester 0 streams 20 beats, requester 1 waits
        do_reset();
        step();
        for (int i = 0; i < 20; i++) push(0, 8'(8'h40 + i), 1'b0);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        for (int i = 0; i < 16; i++) begin exp_d.push_back(8'(8'h40 + i)); exp_s.push_back(0); end
        exp_d.push_back(8'hB0); exp_s.push_back(1);
        exp_d.push_back(8'hB1); exp_s.push_back(1);
        for (int i = 16; i < 20; i++) begin exp_d.push_back(8'(8'h40 + i)); exp_s.push_back(0); end
        wait_wr(22, 120);
        for (int i = 0; i < 22; i++) begin
            chk("t4_data", 32'(wr_data_q[i]), 32'(exp_d[i]));
            chk("t4_src", 32'(wr_src_q[i]), 32'(exp_s[i]));
        end
        chk("t4_grants", 32'(gnt_src_q.size()), 32'd3);
        chk("t4_g0", 32'(gnt_src_q[0]), 32'd0);
        chk("t4_g1", 32'(gnt_src_q[1]), 32'd1);
        chk("t4_g2", 32'(gnt_src_q[2]), 32'd0);
        repeat (3) begin @(negedge clk); #1; end
        chk("t4_held_grant", 32'(grant_o), 32'b0001);
        chk("t4_held_busy", 32'(busy_o), 32'd1);
        chk("t4_total", 32'(wr_data_q.size()), 32'd22);

        // FIFO full for 5 cycles mid-packet of requester 3
        do_reset();
        step();
        for (int i = 0; i < 8; i++) push(3, 8'(8'hC0 + i), 1'(i == 7));
        wait_wr(2, 30);
        step();
        fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            chk("t5_full_wr_en", 32'(fifo_wr_en_o), 32'd0);
            chk("t5_full_ready3", 32'(req_ready_o[3]), 32'd0);
            chk("t5_full_busy", 32'(busy_o), 32'd1);
        end
        chk("t5_stalled_count", 32'(wr_data_q.size()), 32'd2);
        step();
        fifo_full = 1'b0;
        wait_wr(8, 40);
        repeat (3) begin @(negedge clk); #1; end
        chk("t5_total", 32'(wr_data_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("t5_data", 32'(wr_data_q[i]), 32'(8'hC0 + i));
        chk("t5_released", 32'(grant_o), 32'd0);

        // Asynchronous reset mid-packet; arbitration restarts from requester 0
        do_reset();
        step();
        push(1, 8'hD0, 1'b1);
        for (int i = 0; i < 6; i++) push(2, 8'(8'hE0 + i), 1'(i == 5));
        wait_wr(3, 40);
        step();
        rst = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant_o), 32'd0);
        chk("t6_async_busy", 32'(busy_o), 32'd0);
        chk("t6_async_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("t6_async_ready", 32'(req_ready_o), 32'd0);
        for (int k = 0; k < N; k++) src_q[k].delete();
        @(posedge clk); #3;
        rst = 1'b0;
        clear_logs();
        step();
        push(0, 8'hF0, 1'b1); push(3, 8'hF3, 1'b1);
        wait_wr(2, 20);
        chk("t6_first_grant", 32'(gnt_src_q[0]), 32'd0);
        chk("t6_second_grant", 32'(gnt_src_q[1]), 32'd3);
        chk("t6_d0", 32'(wr_data_q[0]), 32'hF0);
        chk("t6_d1", 32'(wr_data_q[1]), 32'hF3);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
